// File: rtl/bkg_seq_ctrl.sv
// Background-accumulation sequencer: steps the background RAM through clear,
// TOTAL_FRAME accumulate frames and subtract, and reports frame-integrity errors.
module bkg_seq_ctrl #(
  parameter int TOTAL_FRAME = 4,
  parameter int NUM_CH      = 256
) (
  input  logic        clk_clk,
  input  logic        rst_reset,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic        sof,
  input  logic        data_valid,
  input  logic [7:0]  data_addr,
  output logic [26:0] frame_id,
  output logic [7:0]  bkg_addr,
  output logic        busy,
  output logic        bkg_ready,
  output logic [16:0] frames_acc,
  output logic        err_short
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam logic [16:0] FID_CLEAR  = 17'd1;
  localparam logic [16:0] FID_FIRST  = 17'd2;
  localparam logic [16:0] FID_LAST   = 17'(TOTAL_FRAME + 1);
  localparam logic [16:0] FID_SUB    = 17'(TOTAL_FRAME + 2);
  localparam logic [7:0]  SWEEP_LAST = 8'(NUM_CH - 1);
  localparam logic [8:0]  BEAT_FULL  = 9'(NUM_CH);

  state_t      r_state;
  logic [16:0] r_frame_id;
  logic [7:0]  r_sweep;
  logic [8:0]  r_beat;
  logic [16:0] r_frames_acc;
  logic        r_err_short;
  logic        r_busy;
  logic        r_bkg_ready;

  logic        w_start_ok;
  logic        w_beat_full;

  // Start is only honoured when no run is in flight.
  assign w_start_ok  = cmd_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_beat_full = (r_beat == BEAT_FULL);

  // NOTE: bkg_addr is a continuous assign with both mux legs covered, so no
  // storage can be inferred; it is the one deliberately unregistered output.
  assign bkg_addr   = (r_state == S_CLEAR) ? r_sweep : data_addr;
  assign frame_id   = {10'd0, r_frame_id};
  assign busy       = r_busy;
  assign bkg_ready  = r_bkg_ready;
  assign frames_acc = r_frames_acc;
  assign err_short  = r_err_short;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below reads the pre-edge values, whatever the statement order.
  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      r_state      <= S_IDLE;
      r_frame_id   <= '0;
      r_sweep      <= '0;
      r_beat       <= '0;
      r_frames_acc <= '0;
      r_err_short  <= 1'b0;
      r_busy       <= 1'b0;
      r_bkg_ready  <= 1'b0;
    end else if (cmd_abort) begin
      // Counters and the error flag stay readable after an abort.
      r_state     <= S_IDLE;
      r_frame_id  <= '0;
      r_busy      <= 1'b0;
      r_bkg_ready <= 1'b0;
    end else if (w_start_ok) begin
      r_state      <= S_CLEAR;
      r_frame_id   <= FID_CLEAR;
      r_sweep      <= '0;
      r_beat       <= '0;
      r_frames_acc <= '0;
      r_err_short  <= 1'b0;
      r_busy       <= 1'b1;
      r_bkg_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_sweep == SWEEP_LAST) begin
            r_state <= S_ARM;
            r_sweep <= '0;
          end else begin
            r_sweep <= r_sweep + 8'd1;
          end
        end

        S_ARM: begin
          // frame_id stays at the clear index here, so stray beats write zeros.
          if (sof) begin
            r_state      <= S_ACCUM;
            r_frame_id   <= FID_FIRST;
            r_frames_acc <= 17'd1;
            r_beat       <= '0;
          end
        end

        S_ACCUM: begin
          if (sof) begin
            if (!w_beat_full) begin
              r_err_short <= 1'b1;
            end
            // A beat coincident with sof is the first beat of the new frame.
            r_beat <= {8'd0, data_valid};
            if (r_frame_id < FID_LAST) begin
              r_frame_id   <= r_frame_id + 17'd1;
              r_frames_acc <= r_frames_acc + 17'd1;
            end else begin
              r_state     <= S_DONE;
              r_frame_id  <= FID_SUB;
              r_busy      <= 1'b0;
              r_bkg_ready <= 1'b1;
            end
          end else if (data_valid && !w_beat_full) begin
            r_beat <= r_beat + 9'd1;
          end
        end

        default: begin
          // IDLE and DONE hold until a command arrives.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bkg_seq_ctrl.sv
// Directed bench for bkg_seq_ctrl with TOTAL_FRAME=4, NUM_CH=256.
module tb_bkg_seq_ctrl;

  logic        clk_clk;
  logic        rst_reset;
  logic        cmd_start;
  logic        cmd_abort;
  logic        sof;
  logic        data_valid;
  logic [7:0]  data_addr;
  logic [26:0] frame_id;
  logic [7:0]  bkg_addr;
  logic        busy;
  logic        bkg_ready;
  logic [16:0] frames_acc;
  logic        err_short;

  int n_pass;
  int n_total;

  bkg_seq_ctrl #(
    .TOTAL_FRAME(4),
    .NUM_CH     (256)
  ) dut (
    .clk_clk   (clk_clk),
    .rst_reset (rst_reset),
    .cmd_start (cmd_start),
    .cmd_abort (cmd_abort),
    .sof       (sof),
    .data_valid(data_valid),
    .data_addr (data_addr),
    .frame_id  (frame_id),
    .bkg_addr  (bkg_addr),
    .busy      (busy),
    .bkg_ready (bkg_ready),
    .frames_acc(frames_acc),
    .err_short (err_short)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
  endtask

  task automatic pulse_abort();
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
  endtask

  task automatic send_sof(input logic with_beat);
    sof        = 1'b1;
    data_valid = with_beat;
    data_addr  = 8'd0;
    step();
    sof        = 1'b0;
    data_valid = 1'b0;
  endtask

  // n beats on consecutive cycles, then the idle gap the readout guarantees.
  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data_addr  = 8'(i);
      step();
    end
    data_valid = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_reset  = 1'b1;
    cmd_start  = 1'b0;
    cmd_abort  = 1'b0;
    sof        = 1'b0;
    data_valid = 1'b0;
    data_addr  = 8'd0;
    step();
    n_total++;
    if (frame_id !== 27'd0) $display("FAIL reset_frame_id: got %0d want 0", frame_id);
    else n_pass++;
    n_total++;
    if ({busy, bkg_ready, err_short} !== 3'b000)
      $display("FAIL reset_flags: got busy/ready/err=%b want 000", {busy, bkg_ready, err_short});
    else n_pass++;
    n_total++;
    if (frames_acc !== 17'd0) $display("FAIL reset_frames_acc: got %0d want 0", frames_acc);
    else n_pass++;
    n_total++;
    if (bkg_addr !== 8'd0) $display("FAIL reset_bkg_addr: got %0d want 0", bkg_addr);
    else n_pass++;
    step();
    rst_reset = 1'b0;
    step();
  endtask

  // Clear sweep: exact length, address ramp, and sof/beats ignored mid-sweep.
  task automatic test_clear();
    pulse_start();
    n_total++;
    if ({frame_id, busy, bkg_ready} !== {27'd1, 1'b1, 1'b0})
      $display("FAIL clear_entry: got fid=%0d busy=%b ready=%b want fid=1 busy=1 ready=0",
               frame_id, busy, bkg_ready);
    else n_pass++;
    data_addr = 8'hAA;
    for (int i = 0; i < 256; i++) begin
      n_total++;
      if (bkg_addr !== 8'(i) || frame_id !== 27'd1 || busy !== 1'b1)
        $display("FAIL clear_sweep[%0d]: got addr=%0d fid=%0d busy=%b want addr=%0d fid=1 busy=1",
                 i, bkg_addr, frame_id, busy, i);
      else n_pass++;
      if (i == 100) begin
        sof        = 1'b1;
        data_valid = 1'b1;
      end
      step();
      sof        = 1'b0;
      data_valid = 1'b0;
    end
    n_total++;
    if (bkg_addr !== 8'hAA || frame_id !== 27'd1 || busy !== 1'b1)
      $display("FAIL clear_to_arm: got addr=%0h fid=%0d busy=%b want addr=aa fid=1 busy=1",
               bkg_addr, frame_id, busy);
    else n_pass++;
  endtask

  // Full run from ARM; frame 4 starts with a beat coincident with its sof.
  task automatic test_accum();
    send_sof(1'b0);
    n_total++;
    if (frame_id !== 27'd2 || frames_acc !== 17'd1)
      $display("FAIL accum_sof1: got fid=%0d acc=%0d want fid=2 acc=1", frame_id, frames_acc);
    else n_pass++;
    send_beats(256);
    data_addr = 8'h3C;
    #1;
    n_total++;
    if (bkg_addr !== 8'h3C) $display("FAIL accum_addr_mux: got %0h want 3c", bkg_addr);
    else n_pass++;

    send_sof(1'b0);
    n_total++;
    if (frame_id !== 27'd3 || frames_acc !== 17'd2)
      $display("FAIL accum_sof2: got fid=%0d acc=%0d want fid=3 acc=2", frame_id, frames_acc);
    else n_pass++;
    send_beats(256);

    send_sof(1'b1);
    n_total++;
    if (frame_id !== 27'd4 || frames_acc !== 17'd3 || err_short !== 1'b0)
      $display("FAIL accum_sof3: got fid=%0d acc=%0d err=%b want fid=4 acc=3 err=0",
               frame_id, frames_acc, err_short);
    else n_pass++;
    send_beats(255);

    send_sof(1'b0);
    n_total++;
    if (frame_id !== 27'd5 || frames_acc !== 17'd4 || err_short !== 1'b0 || bkg_ready !== 1'b0)
      $display("FAIL accum_sof4: got fid=%0d acc=%0d err=%b ready=%b want fid=5 acc=4 err=0 ready=0",
               frame_id, frames_acc, err_short, bkg_ready);
    else n_pass++;
    send_beats(256);

    send_sof(1'b0);
    n_total++;
    if (frame_id !== 27'd6 || bkg_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL accum_done: got fid=%0d ready=%b busy=%b want fid=6 ready=1 busy=0",
               frame_id, bkg_ready, busy);
    else n_pass++;
    n_total++;
    if (frames_acc !== 17'd4 || err_short !== 1'b0)
      $display("FAIL accum_done_stats: got acc=%0d err=%b want acc=4 err=0", frames_acc, err_short);
    else n_pass++;

    send_sof(1'b0);
    n_total++;
    if (frame_id !== 27'd6 || bkg_ready !== 1'b1 || frames_acc !== 17'd4)
      $display("FAIL done_sof_ignored: got fid=%0d ready=%b acc=%0d want fid=6 ready=1 acc=4",
               frame_id, bkg_ready, frames_acc);
    else n_pass++;
  endtask

  // A 200-beat frame sets err_short, which sticks through later frames and DONE.
  task automatic test_short_frame();
    pulse_start();
    n_total++;
    if (frame_id !== 27'd1 || busy !== 1'b1 || bkg_ready !== 1'b0 || frames_acc !== 17'd0)
      $display("FAIL restart_from_done: got fid=%0d busy=%b ready=%b acc=%0d want fid=1 busy=1 ready=0 acc=0",
               frame_id, busy, bkg_ready, frames_acc);
    else n_pass++;
    repeat (256) step();
    send_sof(1'b0);
    send_beats(200);
    n_total++;
    if (err_short !== 1'b0) $display("FAIL short_before_sof: got err=%b want 0", err_short);
    else n_pass++;
    send_sof(1'b0);
    n_total++;
    if (err_short !== 1'b1 || frame_id !== 27'd3)
      $display("FAIL short_detect: got err=%b fid=%0d want err=1 fid=3", err_short, frame_id);
    else n_pass++;
    for (int f = 0; f < 3; f++) begin
      send_beats(256);
      send_sof(1'b0);
    end
    n_total++;
    if (err_short !== 1'b1 || bkg_ready !== 1'b1 || frame_id !== 27'd6 || frames_acc !== 17'd4)
      $display("FAIL short_sticky: got err=%b ready=%b fid=%0d acc=%0d want err=1 ready=1 fid=6 acc=4",
               err_short, bkg_ready, frame_id, frames_acc);
    else n_pass++;
  endtask

  // Start ignored while busy, abort mid-ACCUM, restart, abort beats start.
  task automatic test_abort();
    pulse_start();
    n_total++;
    if (err_short !== 1'b0 || frames_acc !== 17'd0)
      $display("FAIL start_clears_stats: got err=%b acc=%0d want err=0 acc=0", err_short, frames_acc);
    else n_pass++;
    repeat (256) step();
    send_sof(1'b0);
    send_beats(256);
    send_sof(1'b0);
    send_beats(10);
    pulse_start();
    n_total++;
    if (frame_id !== 27'd3 || busy !== 1'b1 || frames_acc !== 17'd2)
      $display("FAIL start_while_busy: got fid=%0d busy=%b acc=%0d want fid=3 busy=1 acc=2",
               frame_id, busy, frames_acc);
    else n_pass++;
    data_addr = 8'h5A;
    pulse_abort();
    n_total++;
    if (frame_id !== 27'd0 || busy !== 1'b0 || bkg_ready !== 1'b0 || frames_acc !== 17'd2)
      $display("FAIL abort_accum: got fid=%0d busy=%b ready=%b acc=%0d want fid=0 busy=0 ready=0 acc=2",
               frame_id, busy, bkg_ready, frames_acc);
    else n_pass++;
    n_total++;
    if (bkg_addr !== 8'h5A) $display("FAIL abort_addr_mux: got %0h want 5a", bkg_addr);
    else n_pass++;
    pulse_start();
    n_total++;
    if (frame_id !== 27'd1 || busy !== 1'b1 || frames_acc !== 17'd0 || bkg_addr !== 8'd0)
      $display("FAIL restart_after_abort: got fid=%0d busy=%b acc=%0d addr=%0d want fid=1 busy=1 acc=0 addr=0",
               frame_id, busy, frames_acc, bkg_addr);
    else n_pass++;
    repeat (20) step();
    cmd_start = 1'b1;
    cmd_abort = 1'b1;
    step();
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    n_total++;
    if (frame_id !== 27'd0 || busy !== 1'b0)
      $display("FAIL abort_beats_start: got fid=%0d busy=%b want fid=0 busy=0", frame_id, busy);
    else n_pass++;
    cmd_start = 1'b1;
    cmd_abort = 1'b1;
    step();
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    n_total++;
    if (frame_id !== 27'd0 || busy !== 1'b0)
      $display("FAIL abort_beats_start_idle: got fid=%0d busy=%b want fid=0 busy=0", frame_id, busy);
    else n_pass++;
  endtask

  // Reset raised mid-cycle during CLEAR must clear outputs before any edge.
  task automatic test_async_reset();
    data_addr = 8'd0;
    pulse_start();
    repeat (50) step();
    n_total++;
    if (bkg_addr !== 8'd50 || frame_id !== 27'd1)
      $display("FAIL pre_reset_sweep: got addr=%0d fid=%0d want addr=50 fid=1", bkg_addr, frame_id);
    else n_pass++;
    #2;
    rst_reset = 1'b1;
    #1;
    n_total++;
    if (frame_id !== 27'd0 || busy !== 1'b0 || bkg_addr !== 8'd0 ||
        bkg_ready !== 1'b0 || frames_acc !== 17'd0 || err_short !== 1'b0)
      $display("FAIL async_reset: got fid=%0d busy=%b addr=%0d ready=%b acc=%0d err=%b want all 0",
               frame_id, busy, bkg_addr, bkg_ready, frames_acc, err_short);
    else n_pass++;
    step();
    rst_reset = 1'b0;
    repeat (3) step();
    n_total++;
    if (frame_id !== 27'd0 || busy !== 1'b0)
      $display("FAIL post_reset_idle: got fid=%0d busy=%b want fid=0 busy=0", frame_id, busy);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_clear();
    test_accum();
    test_short_frame();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bkg_seq_ctrl.md
Name: bkg_seq_ctrl

Overview:
- Sequencer for the background-accumulation RAM. It drives that RAM's frame index and address inputs.
- It turns a host start/abort command and the readout's start-of-frame (SOF) stream into the phase order: clear, accumulate TOTAL_FRAME frames, then hold in subtract.
- It sits between the readout front end, the CSR block and the background RAM. It reports progress and frame-integrity errors back to the CSR block.

Parameters:
- TOTAL_FRAME, 4: frames to accumulate. Power of 2 in [2,65536]; must equal the RAM's setting.
- NUM_CH, 256: channels per frame, which is also the clear-sweep length. Range [2,256].

Ports:
- clk_clk  in  1  system clock.
- rst_reset  in  1  reset, asynchronous, active-high.
- cmd_start  in  1  single-cycle pulse: start a background run.
- cmd_abort  in  1  single-cycle pulse: abandon the run and return to IDLE.
- sof  in  1  single-cycle start-of-frame strobe from the readout.
- data_valid  in  1  readout channel beat valid.
- data_addr  in  8  channel address of the current beat.
- frame_id  out  27  frame index to the RAM: 0 = idle, 1 = clear, 2..TOTAL_FRAME+1 = accumulate, TOTAL_FRAME+2 = subtract.
- bkg_addr  out  8  RAM address.
- busy  out  1  high in CLEAR, ARM and ACCUM.
- bkg_ready  out  1  high in DONE; the background is valid.
- frames_acc  out  17  accumulate frames started in this run.
- err_short  out  1  sticky: an accumulate frame ended with fewer than NUM_CH beats.

Behaviour:
- Reset: state=IDLE, frame_id=0, sweep counter=0, beat counter=0, frames_acc=0, err_short=0, busy=0, bkg_ready=0. Outputs are registered except bkg_addr.
- bkg_addr mux: sweep counter in CLEAR; data_addr in every other state.
- IDLE: frame_id=0.
  - cmd_start moves to CLEAR on the next edge and clears sweep counter, frames_acc and err_short.
- CLEAR: frame_id=1.
  - Sweep counter steps 0..NUM_CH-1, one per cycle.
  - The cycle after counter=NUM_CH-1 is in ARM. CLEAR lasts exactly NUM_CH cycles.
  - sof and data are ignored.
- ARM: frame_id stays 1, so stray beats still write zeros.
  - The first sof moves to ACCUM with frame_id=2, frames_acc=1 and beat counter=0.
- ACCUM:
  - Beat counter increments on each data_valid and saturates at NUM_CH.
  - On each sof, if beat counter < NUM_CH, set err_short. Then clear beat counter.
  - On each sof, if frame_id < TOTAL_FRAME+1: frame_id+1 and frames_acc+1.
  - On a sof with frame_id = TOTAL_FRAME+1: go to DONE with frame_id=TOTAL_FRAME+2; frames_acc stays TOTAL_FRAME.
  - sof and data_valid in the same cycle: the beat belongs to the new frame (counter = 1 after the edge).
- DONE: frame_id holds TOTAL_FRAME+2, bkg_ready=1, sof ignored.
  - cmd_start re-enters CLEAR, behaving as from IDLE.
- cmd_start while busy: ignored.
- cmd_abort in any state: IDLE on the next edge, frame_id=0, bkg_ready=0.
  - frames_acc and err_short are kept for readback.
  - Abort wins over start in the same cycle.
- frame_id changes only on a clock edge after sof. The readout guarantees at least 4 idle cycles between the last beat and the next sof, so the RAM's 3-cycle write pipeline drains.
- frame_id width: 17 significant bits; the upper bits are always 0.

Test Plan:
- Reset, then cmd_start with TOTAL_FRAME=4, NUM_CH=256:
  - CLEAR lasts exactly 256 cycles; bkg_addr goes 0..255; frame_id=1; busy=1.
- From ARM, send 5 sofs, each followed by 256 beats:
  - frame_id goes 2,3,4,5, then 6 on the 5th sof.
  - bkg_ready rises 1 cycle after the 5th sof; frames_acc=4; err_short=0.
- A frame with only 200 beats before the next sof sets err_short=1, which survives later complete frames and DONE.
- cmd_abort mid-ACCUM (frame_id=3) gives IDLE, frame_id=0, busy=0, frames_acc=2. A following cmd_start restarts CLEAR and clears frames_acc to 0.
- cmd_start during ACCUM has no effect. cmd_start and cmd_abort together give IDLE.
- rst_reset asserted mid-CLEAR gives all outputs 0 immediately, without waiting for a clock edge. sof/data_valid during CLEAR do not advance frame_id.
